// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Shares the single register-file write port between the in-order W stage
// and a long-latency unit (LU). LU results wait in a small FIFO and drain
// into cycles where the W stage does not write. A starvation counter forces
// a one-cycle W-stage stall so that a blocked FIFO head can drain.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   RegWriteW, RdW, ResultW    W-stage write request
//   lu_valid, lu_rd, lu_data   LU result offered to the FIFO
//   lu_ready                   FIFO can accept (registered count < DEPTH)
//   rf_we, rf_rd, rf_wd        register-file write port
//   wb_stall                   W stage must re-present its instruction
//   pend_mask                  bit r set while a valid queued entry targets xr
//   perf_force_cnt,
//   perf_block_cnt             optional counters, present only when
//                              WB_PERF_CNT_EN is defined
module wb_port_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RegWriteW,
  input  logic [4:0]  RdW,
  input  logic [31:0] ResultW,
  input  logic        lu_valid,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wd,
  output logic        wb_stall,
  output logic [31:0] pend_mask
`ifdef WB_PERF_CNT_EN
  ,
  output logic [31:0] perf_force_cnt,
  output logic [31:0] perf_block_cnt
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, PEND, FORCE} state_t;

  state_t          state;
  logic [4:0]      rd_mem   [DEPTH];
  logic [31:0]     data_mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic [3:0]      wait_cnt;

  logic            pipe_wr, push, have_valid, force_eff, lu_write, w_grant, blocked;
  logic [PW-1:0]   head_idx, scan_idx;
  logic [CW-1:0]   skip_n, pop_n, count_next;

  assign pipe_wr = RegWriteW && (RdW != 5'd0);
  assign lu_ready = (count < CW'(DEPTH));
  // A zero-destination LU result is accepted but never stored.
  assign push = lu_valid && lu_ready && (lu_rd != 5'd0);

  // Find the first still-valid entry. Killed entries in front of it are
  // popped for free in this cycle (skip_n of them); if none is valid, every
  // occupied slot is skipped.
  always_comb begin
    have_valid = 1'b0;
    head_idx   = rd_ptr;
    skip_n     = count;
    scan_idx   = rd_ptr;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      scan_idx = rd_ptr + PW'(k);
      if ((CW'(k) < count) && vld[scan_idx]) begin
        have_valid = 1'b1;
        head_idx   = scan_idx;
        skip_n     = CW'(k);
      end
    end
  end

  // FORCE only stalls W if there is still a live entry to write.
  assign force_eff  = (state == FORCE) && have_valid;
  assign lu_write   = have_valid && (force_eff || !pipe_wr);
  assign w_grant    = pipe_wr && !force_eff;
  assign blocked    = (state == PEND) && have_valid && pipe_wr;
  assign pop_n      = skip_n + CW'(lu_write);
  assign count_next = count + CW'(push) - pop_n;

  always_comb begin
    rf_we = 1'b0;
    rf_rd = 5'd0;
    rf_wd = 32'd0;
    if (rst_n) begin
      if (lu_write) begin
        rf_we = 1'b1;
        rf_rd = rd_mem[head_idx];
        rf_wd = data_mem[head_idx];
      end else if (w_grant) begin
        rf_we = 1'b1;
        rf_rd = RdW;
        rf_wd = ResultW;
      end
    end
  end

  assign wb_stall = rst_n && force_eff;

  always_comb begin
    pend_mask = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i]) pend_mask[rd_mem[i]] = 1'b1;
    end
    pend_mask[0] = 1'b0;
  end

  // Payload storage carries no reset; occupancy lives in vld/count.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr]   <= lu_rd;
      data_mem[wr_ptr] <= lu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      vld      <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      wait_cnt <= 4'd0;
    end else begin
      // A granted W write is younger than any queued result to the same rd.
      for (int i = 0; i < DEPTH; i++) begin
        if (w_grant && vld[i] && (rd_mem[i] == RdW)) vld[i] <= 1'b0;
      end
      for (int k = 0; k < DEPTH; k++) begin
        if (CW'(k) < pop_n) vld[rd_ptr + PW'(k)] <= 1'b0;
      end
      // The push slot is never occupied, so it cannot collide with the above.
      if (push) begin
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      // pop_n never exceeds DEPTH, so truncation gives the modulo wrap.
      rd_ptr <= rd_ptr + pop_n[PW-1:0];
      count  <= count_next;

      if (count_next == '0) begin
        state    <= IDLE;
        wait_cnt <= 4'd0;
      end else if (blocked && (wait_cnt == 4'(STARVE_LIMIT - 1))) begin
        state    <= FORCE;
        wait_cnt <= 4'd0;
      end else begin
        state <= PEND;
        if (pop_n != '0)  wait_cnt <= 4'd0;
        else if (blocked) wait_cnt <= wait_cnt + 4'd1;
      end
    end
  end

`ifdef WB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_force_cnt <= 32'd0;
      perf_block_cnt <= 32'd0;
    end else begin
      if (state == FORCE) perf_force_cnt <= perf_force_cnt + 32'd1;
      if (blocked)        perf_block_cnt <= perf_block_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wd;
  logic        wb_stall;
  logic [31:0] pend_mask;
`ifdef WB_PERF_CNT_EN
  logic [31:0] perf_force_cnt;
  logic [31:0] perf_block_cnt;
`endif

  int checks = 0;
  int errors = 0;

  wb_port_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data),
    .lu_ready(lu_ready),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd),
    .wb_stall(wb_stall), .pend_mask(pend_mask)
`ifdef WB_PERF_CNT_EN
    , .perf_force_cnt(perf_force_cnt), .perf_block_cnt(perf_block_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] rd, input logic [31:0] res,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
    RegWriteW = we; RdW = rd; ResultW = res;
    lu_valid = lv; lu_rd = lrd; lu_data = ld;
    #1;
  endtask

  initial begin
    // Reset with traffic held on both sides
    rst_n = 1'b0;
    drive(1'b1, 5'd3, 32'h2, 1'b1, 5'd5, 32'h1);
    tick(); tick();
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_rf_rd", 32'(rf_rd), 32'd0);
    chk("rst_rf_wd", rf_wd, 32'd0);
    chk("rst_stall", 32'(wb_stall), 32'd0);
    chk("rst_ready", 32'(lu_ready), 32'd1);
    chk("rst_mask", pend_mask, 32'd0);
    rst_n = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("post_rst_we", 32'(rf_we), 32'd0);
    chk("post_rst_mask", pend_mask, 32'd0);
    $display("txn reset done");
    tick();

    // Idle push: written the next cycle, no bypass
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hDEADBEEF);
    chk("idle_nobypass_we", 32'(rf_we), 32'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("idle_we", 32'(rf_we), 32'd1);
    chk("idle_rd", 32'(rf_rd), 32'd5);
    chk("idle_wd", rf_wd, 32'hDEADBEEF);
    chk("idle_mask", pend_mask, 32'h20);
    tick();
    chk("idle_after_we", 32'(rf_we), 32'd0);
    chk("idle_after_mask", pend_mask, 32'd0);
    $display("txn idle push rd=5");

    // Starvation: four blocked W cycles then one forced drain
    drive(1'b1, 5'd7, 32'h77, 1'b1, 5'd9, 32'h99);
    chk("starve_w0_rd", 32'(rf_rd), 32'd7);
    tick();
    for (int c = 1; c <= 4; c++) begin
      drive(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'h0);
      chk($sformatf("starve_w%0d_rd", c), 32'(rf_rd), 32'd7);
      chk($sformatf("starve_w%0d_stall", c), 32'(wb_stall), 32'd0);
      tick();
    end
    chk("force_rd", 32'(rf_rd), 32'd9);
    chk("force_wd", rf_wd, 32'h99);
    chk("force_stall", 32'(wb_stall), 32'd1);
    tick();
    chk("force_after_rd", 32'(rf_rd), 32'd7);
    chk("force_after_wd", rf_wd, 32'h77);
    chk("force_after_stall", 32'(wb_stall), 32'd0);
    chk("force_after_mask", pend_mask, 32'd0);
    $display("txn starvation rd=9");
    tick();

    // Fill the FIFO behind a busy W stage
    drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd3, 32'h33);
    chk("fill0_ready", 32'(lu_ready), 32'd1);
    tick();
    drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd4, 32'h44);
    chk("fill1_ready", 32'(lu_ready), 32'd1);
    tick();
    drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd6, 32'h66);
    chk("full_ready", 32'(lu_ready), 32'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("pop_cycle_ready", 32'(lu_ready), 32'd0);
    chk("pop0_rd", 32'(rf_rd), 32'd3);
    chk("pop0_wd", rf_wd, 32'h33);
    chk("pop0_mask", pend_mask, 32'h18);
    tick();
    chk("pop1_ready", 32'(lu_ready), 32'd1);
    chk("pop1_rd", 32'(rf_rd), 32'd4);
    chk("pop1_wd", rf_wd, 32'h44);
    chk("pop1_mask", pend_mask, 32'h10);
    tick();
    chk("fill_drained_we", 32'(rf_we), 32'd0);
    chk("fill_drained_mask", pend_mask, 32'd0);
    $display("txn fill rd=3,4 with rejected rd=6");
    tick();

    // WAW kill of a queued entry by a younger W write
    drive(1'b1, 5'd7, 32'h77, 1'b1, 5'd12, 32'hCC);
    tick();
    drive(1'b1, 5'd12, 32'h1212, 1'b0, 5'd0, 32'h0);
    chk("waw_w_rd", 32'(rf_rd), 32'd12);
    chk("waw_w_wd", rf_wd, 32'h1212);
    chk("waw_mask_before", pend_mask, 32'h1000);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("waw_killed_we", 32'(rf_we), 32'd0);
    chk("waw_killed_mask", pend_mask, 32'd0);
    $display("txn waw kill rd=12");
    tick();

    // lu_rd=0 push is swallowed
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h55);
    chk("rd0_push_we", 32'(rf_we), 32'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("rd0_after_we", 32'(rf_we), 32'd0);
    chk("rd0_after_mask", pend_mask, 32'd0);
    chk("rd0_after_ready", 32'(lu_ready), 32'd1);
    $display("txn lu_rd=0 push");
    tick();

    // RdW=0 frees the port for a queued entry
    drive(1'b1, 5'd3, 32'h3333, 1'b1, 5'd8, 32'h88);
    chk("x0_w_rd", 32'(rf_rd), 32'd3);
    tick();
    drive(1'b1, 5'd0, 32'hABC, 1'b0, 5'd0, 32'h0);
    chk("x0_drain_we", 32'(rf_we), 32'd1);
    chk("x0_drain_rd", 32'(rf_rd), 32'd8);
    chk("x0_drain_wd", rf_wd, 32'h88);
    chk("x0_drain_stall", 32'(wb_stall), 32'd0);
    tick();
    chk("x0_after_we", 32'(rf_we), 32'd0);
    chk("x0_after_mask", pend_mask, 32'd0);
    $display("txn RdW=0 drain rd=8");
    tick();

    // Reset in the middle of operation drops queued work
    drive(1'b1, 5'd3, 32'h3333, 1'b1, 5'd10, 32'hAA);
    tick();
    rst_n = 1'b0;
    drive(1'b1, 5'd3, 32'h3333, 1'b0, 5'd0, 32'h0);
    chk("midrst_we", 32'(rf_we), 32'd0);
    chk("midrst_stall", 32'(wb_stall), 32'd0);
    tick();
    rst_n = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("midrst_after_we", 32'(rf_we), 32'd0);
    chk("midrst_after_mask", pend_mask, 32'd0);
    chk("midrst_after_ready", 32'(lu_ready), 32'd1);
    $display("txn mid-operation reset");
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
